lcd_frame_writer: RTL and testbench

LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

---
 rtl/lcd_game_pkg.sv | 44 ++++
 rtl/lcd_write_strobe.sv | 52 +++++
 rtl/lcd_frame_writer.sv | 133 +++++++++++++
 tb/tb_lcd_frame_writer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_game_pkg.sv
// Shared character codes, LCD commands, frame FSM states and the glyph
// selection rule used when the screen is redrawn.
package lcd_game_pkg;

   localparam logic [7:0] CHR_BUNNY = 8'h06;
   localparam logic [7:0] CHR_BLOCK = 8'h02;
   localparam logic [7:0] CHR_SPACE = 8'h20;
   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;

   localparam logic [3:0] LAST_COL  = 4'd15;

   typedef enum logic [2:0] {
      IDLE,
      ADDR1,
      ROW1,
      ADDR2,
      ROW2,
      DONE
   } frame_state_t;

   // Bunny wins over an obstacle sharing its cell; obstacles only live on the bottom row.
   function automatic logic [7:0] cell_char(
      input logic        bottom,
      input logic [3:0]  col,
      input logic [3:0]  bunny_col,
      input logic [15:0] map,
      input logic        up
   );
      logic [7:0] chr;
      chr = CHR_SPACE;
      if (bottom) begin
         if (!up && (col == bunny_col)) begin
            chr = CHR_BUNNY;
         end else if (map[col]) begin
            chr = CHR_BLOCK;
         end
      end else if (up && (col == bunny_col)) begin
         chr = CHR_BUNNY;
      end
      return chr;
   endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD write: latches data/rs on start, then drives lcd_en high for EN_HOLD
// clocks and low for EN_HOLD clocks; done marks the last low clock.
module lcd_write_strobe #(
   parameter int EN_HOLD = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   input  logic       rs,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_en,
   output logic       done
);

   localparam logic [7:0] HOLD_LAST = 8'(EN_HOLD - 1);

   logic       active;
   logic [7:0] hold_cnt;

   // A new start on the done cycle chains writes back to back with no gap.
   assign done = active && !lcd_en && (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         active   <= 1'b0;
         lcd_en   <= 1'b0;
         hold_cnt <= 8'd0;
         lcd_data <= 8'h00;
         lcd_rs   <= 1'b0;
      end else if (start) begin
         active   <= 1'b1;
         lcd_en   <= 1'b1;
         hold_cnt <= 8'd0;
         lcd_data <= data;
         lcd_rs   <= rs;
      end else if (active) begin
         if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= 8'd0;
            if (lcd_en) begin
               lcd_en <= 1'b0;
            end else begin
               active <= 1'b0;
            end
         end else begin
            hold_cnt <= hold_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/lcd_frame_writer.sv
// Redraws the 2x16 game screen: line-1 address, 16 top cells, line-2 address,
// 16 bottom cells, then reports frame_done and the bunny/obstacle collision.
module lcd_frame_writer
   import lcd_game_pkg::*;
#(
   parameter int EN_HOLD   = 1,
   parameter int BUNNY_COL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_end,
   input  logic        frame_start,
   input  logic [15:0] obstacle_map,
   input  logic        bunny_up,
   output logic [7:0]  lcd_data,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_en,
   output logic        busy,
   output logic        frame_done,
   output logic        collision
);

   localparam logic [3:0] BCOL = 4'(BUNNY_COL);

   frame_state_t state;
   frame_state_t next_state;

   logic [3:0]  col;
   logic [3:0]  col_next;
   logic        kick;
   logic        accept;
   logic        last_write;
   logic        wr_done;
   logic        wr_start;
   logic        wr_rs;
   logic [7:0]  wr_data;
   logic [15:0] cap_map;
   logic        cap_up;

   assign lcd_rw     = 1'b0;
   assign accept     = (state == IDLE) && frame_start && init_end;
   assign last_write = (state == ROW2) && wr_done && (col == LAST_COL);
   assign col_next   = (wr_done && ((state == ROW1) || (state == ROW2))) ? col + 4'd1 : col;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (accept) next_state = ADDR1;
         ADDR1: if (wr_done) next_state = ROW1;
         ROW1:  if (wr_done && (col == LAST_COL)) next_state = ADDR2;
         ADDR2: if (wr_done) next_state = ROW2;
         ROW2:  if (wr_done && (col == LAST_COL)) next_state = DONE;
         DONE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The byte launched on a done edge belongs to the write that follows, so it
   // is selected from the next state and column rather than the current ones.
   always_comb begin
      wr_data  = 8'h00;
      wr_rs    = 1'b0;
      wr_start = kick || (wr_done && (next_state != DONE));
      case (next_state)
         ADDR1: wr_data = CMD_LINE1;
         ROW1: begin
            wr_data = cell_char(1'b0, col_next, BCOL, cap_map, cap_up);
            wr_rs   = 1'b1;
         end
         ADDR2: wr_data = CMD_LINE2;
         ROW2: begin
            wr_data = cell_char(1'b1, col_next, BCOL, cap_map, cap_up);
            wr_rs   = 1'b1;
         end
         default: begin
            wr_data = 8'h00;
            wr_rs   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= 4'd0;
         kick       <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         collision  <= 1'b0;
         cap_map    <= 16'h0000;
         cap_up     <= 1'b0;
      end else begin
         col        <= col_next;
         kick       <= accept;
         frame_done <= last_write;
         if (kick) begin
            busy <= 1'b1;
         end else if (last_write) begin
            busy <= 1'b0;
         end
         if (accept) begin
            cap_map   <= obstacle_map;
            cap_up    <= bunny_up;
            collision <= 1'b0;
         end else if (last_write) begin
            collision <= !cap_up && cap_map[BCOL];
         end
      end
   end

   lcd_write_strobe #(
      .EN_HOLD(EN_HOLD)
   ) u_strobe (
      .clk      (clk),
      .rst      (rst),
      .start    (wr_start),
      .data     (wr_data),
      .rs       (wr_rs),
      .lcd_data (lcd_data),
      .lcd_rs   (lcd_rs),
      .lcd_en   (lcd_en),
      .done     (wr_done)
   );

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: two instances (EN_HOLD 1 and 3) share stimulus and
// are checked each cycle against a timeline model, plus directed literal frames.
module tb_lcd_frame_writer;

   localparam int BC = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_end;
   logic        frame_start;
   logic [15:0] obstacle_map;
   logic        bunny_up;

   logic [7:0] data0, data3;
   logic       rs0, rs3, rw0, rw3, en0, en3;
   logic       busy0, busy3, fd0, fd3, coll0, coll3;

   always #5 clk = ~clk;

   lcd_frame_writer #(.EN_HOLD(1), .BUNNY_COL(BC)) dut (
      .clk(clk), .rst(rst), .init_end(init_end), .frame_start(frame_start),
      .obstacle_map(obstacle_map), .bunny_up(bunny_up),
      .lcd_data(data0), .lcd_rs(rs0), .lcd_rw(rw0), .lcd_en(en0),
      .busy(busy0), .frame_done(fd0), .collision(coll0)
   );

   lcd_frame_writer #(.EN_HOLD(3), .BUNNY_COL(BC)) dut3 (
      .clk(clk), .rst(rst), .init_end(init_end), .frame_start(frame_start),
      .obstacle_map(obstacle_map), .bunny_up(bunny_up),
      .lcd_data(data3), .lcd_rs(rs3), .lcd_rw(rw3), .lcd_en(en3),
      .busy(busy3), .frame_done(fd3), .collision(coll3)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: frame timeline per instance ----------------
   int         cyc = 0;
   int         HH[2] = '{1, 3};
   int         m_rel[2] = '{-1, -1};   // edges since the accepting edge, -1 = no frame
   logic       m_coll[2] = '{1'b0, 1'b0};
   logic       m_up[2];
   logic [15:0] m_map[2];
   logic [7:0] m_bytes[2][34];

   initial begin : model
      int h;
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            h = HH[i];
            if (rst) begin
               m_rel[i]  = -1;
               m_coll[i] = 1'b0;
            end else if ((m_rel[i] < 0 || m_rel[i] >= 68 * h + 2) && frame_start && init_end) begin
               m_rel[i]  = 0;
               m_coll[i] = 1'b0;
               m_up[i]   = bunny_up;
               m_map[i]  = obstacle_map;
               m_bytes[i][0]  = 8'h80;
               m_bytes[i][17] = 8'hC0;
               for (int c = 0; c < 16; c++) begin
                  m_bytes[i][1 + c]  = (bunny_up && c == BC) ? 8'h06 : 8'h20;
                  m_bytes[i][18 + c] = (!bunny_up && c == BC) ? 8'h06 :
                                       (obstacle_map[c] ? 8'h02 : 8'h20);
               end
            end else if (m_rel[i] >= 0) begin
               m_rel[i]++;
               if (m_rel[i] == 68 * h + 1) m_coll[i] = !m_up[i] && m_map[i][BC];
            end
         end
      end
   end

   initial begin : compare
      int e, h, k;
      logic [7:0] d;
      logic r, w, en, b, fd, co;
      logic x_en, x_busy, x_fd;
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
               e = m_rel[i];
               h = HH[i];
               if (i == 0) begin
                  d = data0; r = rs0; w = rw0; en = en0; b = busy0; fd = fd0; co = coll0;
               end else begin
                  d = data3; r = rs3; w = rw3; en = en3; b = busy3; fd = fd3; co = coll3;
               end
               x_busy = (e >= 1) && (e <= 68 * h);
               x_en   = x_busy && (((e - 1) % (2 * h)) < h);
               x_fd   = (e == 68 * h + 1);
               chk($sformatf("lcd_en[h%0d]", h), 32'(en), 32'(x_en));
               chk($sformatf("busy[h%0d]", h), 32'(b), 32'(x_busy));
               chk($sformatf("frame_done[h%0d]", h), 32'(fd), 32'(x_fd));
               chk($sformatf("collision[h%0d]", h), 32'(co), 32'(m_coll[i]));
               chk($sformatf("lcd_rw[h%0d]", h), 32'(w), 32'd0);
               if (x_busy) begin
                  k = (e - 1) / (2 * h);
                  chk($sformatf("lcd_data[h%0d] write %0d", h, k), 32'(d), 32'(m_bytes[i][k]));
                  chk($sformatf("lcd_rs[h%0d] write %0d", h, k), 32'(r), (k == 0 || k == 17) ? 32'd0 : 32'd1);
               end
            end
         end
      end
   end

   // ---------------- monitors for directed literal checks ----------------
   logic       en0_prev = 1'b0;
   logic       en3_prev = 1'b0;
   logic [8:0] wq[$];
   int         fd0_cnt = 0;
   int         en3_high = 0;
   int         en3_rises = 0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (en0 === 1'b1 && en0_prev !== 1'b1) wq.push_back({rs0, data0});
         if (fd0 === 1'b1) fd0_cnt++;
         if (en3 === 1'b1) begin
            en3_high++;
            if (en3_prev !== 1'b1) en3_rises++;
         end
         en0_prev = en0;
         en3_prev = en3;
      end
   end

   logic [8:0] exp_w[34];

   task automatic blank_exp();
      exp_w[0]  = 9'h080;
      exp_w[17] = 9'h0C0;
      for (int c = 0; c < 16; c++) begin
         exp_w[1 + c]  = 9'h120;
         exp_w[18 + c] = 9'h120;
      end
   endtask

   task automatic check_writes(input string nm);
      chk({nm, " write count"}, 32'(wq.size()), 32'd34);
      if (wq.size() == 34) begin
         for (int j = 0; j < 34; j++) chk($sformatf("%s write %0d", nm, j), 32'(wq[j]), 32'(exp_w[j]));
      end
   endtask

   task automatic start_frame(input logic [15:0] map, input logic up, output int t);
      @(negedge clk);
      obstacle_map = map;
      bunny_up     = up;
      frame_start  = 1'b1;
      t            = cyc + 1;
      @(negedge clk);
      frame_start  = 1'b0;
   endtask

   task automatic wait_fd(input int inst, input int limit, output int t);
      t = -1;
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (((inst == 0) ? fd0 : fd3) === 1'b1) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_fd inst %0d: got no frame_done, required one within %0d cycles", inst, limit);
      end
   endtask

   initial begin : driver
      int t, tf, c0;
      rst          = 1'b1;
      init_end     = 1'b0;
      frame_start  = 1'b0;
      obstacle_map = 16'h0000;
      bunny_up     = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset lcd_data", 32'(data0), 32'h00);
      chk("reset lcd_rs", 32'(rs0), 32'd0);
      chk("reset lcd_en", 32'(en0), 32'd0);
      chk("reset busy", 32'(busy0), 32'd0);
      chk("reset frame_done", 32'(fd0), 32'd0);
      chk("reset collision", 32'(coll0), 32'd0);
      rst      = 1'b0;
      init_end = 1'b1;
      repeat (2) @(negedge clk);

      // empty field, bunny on the bottom row
      wq.delete();
      start_frame(16'h0000, 1'b0, t);
      wait_fd(0, 200, tf);
      chk("empty frame_done time", 32'(tf - t), 32'd69);
      chk("empty collision", 32'(coll0), 32'd0);
      blank_exp();
      exp_w[19] = 9'h106;
      check_writes("empty");
      repeat (3) @(negedge clk);

      // obstacles at 0, 1, 15 with the bunny sitting on column 1
      wq.delete();
      start_frame(16'h8003, 1'b0, t);
      wait_fd(0, 200, tf);
      chk("hit collision", 32'(coll0), 32'd1);
      blank_exp();
      exp_w[18] = 9'h102;
      exp_w[19] = 9'h106;
      exp_w[33] = 9'h102;
      check_writes("hit");
      repeat (3) @(negedge clk);
      chk("hit collision held", 32'(coll0), 32'd1);

      // bunny jumping over the obstacle in its column
      wq.delete();
      start_frame(16'h0002, 1'b1, t);
      wait_fd(0, 200, tf);
      chk("jump collision", 32'(coll0), 32'd0);
      blank_exp();
      exp_w[2]  = 9'h106;
      exp_w[19] = 9'h102;
      check_writes("jump");
      repeat (3) @(negedge clk);

      // ignored requests: init not done, then a second request while busy
      init_end = 1'b0;
      c0 = fd0_cnt;
      wq.delete();
      start_frame(16'hFFFF, 1'b0, t);
      repeat (4) @(negedge clk);
      chk("no init busy", 32'(busy0), 32'd0);
      chk("no init writes", 32'(wq.size()), 32'd0);
      init_end = 1'b1;
      start_frame(16'h0000, 1'b0, t);
      repeat (5) @(negedge clk);
      start_frame(16'hFFFF, 1'b1, tf);
      wait_fd(0, 200, tf);
      repeat (150) @(negedge clk);
      chk("single frame_done count", 32'(fd0_cnt - c0), 32'd1);
      blank_exp();
      exp_w[19] = 9'h106;
      check_writes("ignore busy");

      // reset in the middle of a frame
      start_frame(16'h00F0, 1'b0, t);
      while (cyc < t + 20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset lcd_en", 32'(en0), 32'd0);
      chk("midreset busy", 32'(busy0), 32'd0);
      rst = 1'b0;
      c0 = fd0_cnt;
      repeat (100) @(negedge clk);
      chk("midreset no frame_done", 32'(fd0_cnt - c0), 32'd0);
      start_frame(16'h0000, 1'b0, t);
      wait_fd(0, 200, tf);
      chk("after reset frame_done time", 32'(tf - t), 32'd69);
      repeat (260) @(negedge clk);

      // slow strobe instance
      en3_high  = 0;
      en3_rises = 0;
      start_frame(16'h1234, 1'b0, t);
      wait_fd(1, 400, tf);
      chk("hold3 frame_done time", 32'(tf - t), 32'd205);
      chk("hold3 enable high cycles", 32'(en3_high), 32'd102);
      chk("hold3 enable pulses", 32'(en3_rises), 32'd34);
      repeat (5) @(negedge clk);

      // randomized traffic incl. init_end drops mid-frame and rare resets
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         frame_start  = ($urandom_range(0, 9) == 0);
         obstacle_map = 16'($urandom);
         bunny_up     = 1'($urandom);
         if ($urandom_range(0, 59) == 0) init_end = ~init_end;
         rst = ($urandom_range(0, 999) == 0);
      end
      @(negedge clk);
      rst         = 1'b0;
      frame_start = 1'b0;
      init_end    = 1'b1;
      repeat (300) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
